// File: rtl/ula_operand_fetch.sv
// Bus-side operand loader for the ULA: captures two consecutive valid bus words and holds them
// until the ULA acknowledges. The optional fetch timeout is enabled by defining ULA_FETCH_TIMEOUT_EN.
module ula_operand_fetch #(
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_bus,
    input  logic             bus_valid,
    input  logic             start,
    input  logic             ula_ack,
    output logic             bus_grab,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic             operands_ready,
    output logic             busy,
    output logic             timeout_err
);

`ifdef ULA_FETCH_TIMEOUT_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_READY,
        S_ERROR
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_READY
    } state_t;
`endif

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] operand_a_reg;
    logic [WIDTH-1:0] operand_b_reg;
    logic             in_load;
    logic             timeout_hit;

    assign in_load = (state_reg == S_LOAD_A) || (state_reg == S_LOAD_B);

`ifdef ULA_FETCH_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] wait_cnt_reg;
    logic             timeout_err_reg;

    // Terminal count only fires when the bus is still idle; a word on that cycle wins.
    assign timeout_hit = in_load && !bus_valid && (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt_reg    <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (in_load && !bus_valid && !timeout_hit) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end else begin
                wait_cnt_reg <= '0;
            end
            timeout_err_reg <= (state_next == S_ERROR);
        end
    end

    assign timeout_err = timeout_err_reg;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_LOAD_A;
            end
            S_LOAD_A: begin
                if (bus_valid)        state_next = S_LOAD_B;
`ifdef ULA_FETCH_TIMEOUT_EN
                else if (timeout_hit) state_next = S_ERROR;
`endif
            end
            S_LOAD_B: begin
                if (bus_valid)        state_next = S_READY;
`ifdef ULA_FETCH_TIMEOUT_EN
                else if (timeout_hit) state_next = S_ERROR;
`endif
            end
            S_READY: begin
                // ack together with start chains straight into the next fetch
                if (ula_ack) state_next = start ? S_LOAD_A : S_IDLE;
            end
`ifdef ULA_FETCH_TIMEOUT_EN
            S_ERROR: begin
                if (start) state_next = S_LOAD_A;
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            operand_a_reg <= '0;
            operand_b_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_LOAD_A && bus_valid) operand_a_reg <= data_bus;
            if (state_reg == S_LOAD_B && bus_valid) operand_b_reg <= data_bus;
        end
    end

    assign bus_grab       = in_load;
    assign operands_ready = (state_reg == S_READY);
    assign busy           = in_load || (state_reg == S_READY);
    assign operand_a      = operand_a_reg;
    assign operand_b      = operand_b_reg;

endmodule

// File: tb/tb_ula_operand_fetch.sv
// Testbench for ula_operand_fetch: directed scenarios plus random traffic, all outputs checked
// every cycle against a word-counting reference model.
module tb_ula_operand_fetch;

    localparam int WIDTH          = 8;
    localparam int TIMEOUT_CYCLES = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] data_bus = '0;
    logic             bus_valid = 1'b0;
    logic             start = 1'b0;
    logic             ula_ack = 1'b0;
    logic             bus_grab;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             operands_ready;
    logic             busy;
    logic             timeout_err;

    int checks = 0;
    int errors = 0;

    ula_operand_fetch #(
        .WIDTH         (WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .data_bus      (data_bus),
        .bus_valid     (bus_valid),
        .start         (start),
        .ula_ack       (ula_ack),
        .bus_grab      (bus_grab),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .operands_ready(operands_ready),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    always #5 clock = ~clock;

    // Reference model: a fetch is "active" until two valid words have arrived; then "ready"
    // until acknowledged. An error flag is raised by too long a run of idle bus cycles.
    logic             m_active;
    logic             m_ready;
    logic             m_err;
    int               m_words;
    int               m_wait;
    logic [WIDTH-1:0] m_a;
    logic [WIDTH-1:0] m_b;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_active <= 1'b0;
            m_ready  <= 1'b0;
            m_err    <= 1'b0;
            m_words  <= 0;
            m_wait   <= 0;
            m_a      <= '0;
            m_b      <= '0;
        end else if (m_ready) begin
            if (ula_ack) begin
                m_ready  <= 1'b0;
                m_active <= start;
                m_words  <= 0;
                m_wait   <= 0;
            end
        end else if (m_active) begin
            if (bus_valid) begin
                if (m_words == 0) m_a <= data_bus;
                else              m_b <= data_bus;
                m_words <= m_words + 1;
                m_wait  <= 0;
                if (m_words == 1) begin
                    m_active <= 1'b0;
                    m_ready  <= 1'b1;
                end
            end else begin
`ifdef ULA_FETCH_TIMEOUT_EN
                if (m_wait == TIMEOUT_CYCLES - 1) begin
                    m_active <= 1'b0;
                    m_err    <= 1'b1;
                end else begin
                    m_wait <= m_wait + 1;
                end
`endif
            end
        end else if (start) begin
            m_active <= 1'b1;
            m_err    <= 1'b0;
            m_words  <= 0;
            m_wait   <= 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clock) begin
        check("model_bus_grab", 32'(bus_grab), 32'(m_active));
        check("model_busy", 32'(busy), 32'(m_active | m_ready));
        check("model_ready", 32'(operands_ready), 32'(m_ready));
        check("model_timeout_err", 32'(timeout_err), 32'(m_err));
        check("model_operand_a", 32'(operand_a), 32'(m_a));
        check("model_operand_b", 32'(operand_b), 32'(m_b));
    end

    task automatic cycle(input logic s, input logic a, input logic v, input logic [WIDTH-1:0] d);
        @(negedge clock);
        #1;
        start     = s;
        ula_ack   = a;
        bus_valid = v;
        data_bus  = d;
    endtask

    initial begin
        // Reset state
        #2;
        check("reset_bus_grab", 32'(bus_grab), 32'd0);
        check("reset_ready", 32'(operands_ready), 32'd0);
        check("reset_operand_a", 32'(operand_a), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // 1: basic fetch 3C / 5A
        cycle(1, 0, 0, 8'h00);
        cycle(0, 0, 1, 8'h3C);
        check("t1_grab_load_a", 32'(bus_grab), 32'd1);
        cycle(0, 0, 1, 8'h5A);
        check("t1_not_ready_yet", 32'(operands_ready), 32'd0);
        cycle(0, 0, 0, 8'h00);
        check("t1_ready", 32'(operands_ready), 32'd1);
        check("t1_operand_a", 32'(operand_a), 32'h3C);
        check("t1_operand_b", 32'(operand_b), 32'h5A);
        $display("txn t1: a=%0h b=%0h ready=%0b", operand_a, operand_b, operands_ready);
        cycle(0, 1, 0, 8'h00);
        cycle(0, 0, 0, 8'h00);
        check("t1_idle_after_ack", 32'(busy), 32'd0);
        check("t1_operand_a_held", 32'(operand_a), 32'h3C);

        // 2: stalled bus with toggling data
        cycle(1, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 8'(8'h10 + i));
        cycle(0, 0, 1, 8'h77);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 8'(8'hE0 + i));
            check("t2_grab_stall", 32'(bus_grab), 32'd1);
            check("t2_not_ready", 32'(operands_ready), 32'd0);
        end
        cycle(0, 0, 1, 8'h99);
        cycle(0, 0, 0, 8'h00);
        check("t2_operand_a", 32'(operand_a), 32'h77);
        check("t2_operand_b", 32'(operand_b), 32'h99);
        check("t2_ready", 32'(operands_ready), 32'd1);
        $display("txn t2: a=%0h b=%0h", operand_a, operand_b);

        // 3: back-to-back fetch
        cycle(1, 1, 0, 8'h00);
        cycle(0, 0, 1, 8'h01);
        check("t3_straight_to_load", 32'(bus_grab), 32'd1);
        cycle(0, 0, 1, 8'hFF);
        cycle(0, 0, 0, 8'h00);
        check("t3_operand_a", 32'(operand_a), 32'h01);
        check("t3_operand_b", 32'(operand_b), 32'hFF);
        $display("txn t3: a=%0h b=%0h", operand_a, operand_b);

        // 4: ignored start/ack
        cycle(1, 0, 0, 8'h00);
        check("t4_start_ignored_ready", 32'(operands_ready), 32'd1);
        cycle(0, 1, 0, 8'h00);
        cycle(0, 1, 0, 8'h00);
        cycle(0, 0, 0, 8'h00);
        check("t4_ack_in_idle", 32'(busy), 32'd0);
        cycle(1, 0, 0, 8'h00);
        cycle(1, 1, 0, 8'h00);
        cycle(1, 0, 1, 8'h42);
        cycle(1, 1, 0, 8'h00);
        check("t4_still_load_b", 32'(bus_grab), 32'd1);
        check("t4_operand_b_kept", 32'(operand_b), 32'hFF);
        cycle(0, 0, 1, 8'h24);
        cycle(0, 0, 0, 8'h00);
        check("t4_operand_a", 32'(operand_a), 32'h42);
        check("t4_operand_b", 32'(operand_b), 32'h24);
        $display("txn t4: a=%0h b=%0h", operand_a, operand_b);
        cycle(0, 1, 0, 8'h00);

        // 5: async reset in LOAD_B
        cycle(1, 0, 0, 8'h00);
        cycle(0, 0, 1, 8'hAA);
        cycle(0, 0, 0, 8'h00);
        @(posedge clock);
        #3;
        check("t5_captured_aa", 32'(operand_a), 32'hAA);
        reset = 1'b0;
        #1;
        check("t5_operand_a_cleared", 32'(operand_a), 32'd0);
        check("t5_grab_cleared", 32'(bus_grab), 32'd0);
        check("t5_busy_cleared", 32'(busy), 32'd0);
        $display("txn t5: reset mid-fetch a=%0h busy=%0b", operand_a, busy);
        @(negedge clock);
        reset = 1'b1;

        // 6: idle bus for TIMEOUT_CYCLES cycles in LOAD_A
        cycle(1, 0, 0, 8'h00);
        for (int i = 0; i < TIMEOUT_CYCLES; i++) cycle(0, 0, 0, 8'h00);
        cycle(0, 0, 0, 8'h00);
`ifdef ULA_FETCH_TIMEOUT_EN
        check("t6_timeout_err", 32'(timeout_err), 32'd1);
        check("t6_busy_low", 32'(busy), 32'd0);
        cycle(1, 0, 0, 8'h00);
        cycle(0, 0, 0, 8'h00);
        check("t6_err_cleared", 32'(timeout_err), 32'd0);
        check("t6_load_a_again", 32'(bus_grab), 32'd1);
`else
        check("t6_no_timeout", 32'(timeout_err), 32'd0);
        check("t6_still_loading", 32'(bus_grab), 32'd1);
`endif
        $display("txn t6: timeout_err=%0b busy=%0b", timeout_err, busy);
        cycle(0, 0, 1, 8'h11);
        cycle(0, 0, 1, 8'h22);
        cycle(0, 1, 0, 8'h00);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(3) == 0), ($urandom_range(2) == 0),
                  ($urandom_range(1) == 0), 8'($urandom));
            if (operands_ready)
                $display("txn rnd %0d: a=%0h b=%0h", i, operand_a, operand_b);
        end
        cycle(0, 0, 0, 8'h00);
        @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
